// File: rtl/axi4_lite_slave_read_pipe.sv
// AXI4-Lite read slave: in-order AR FIFO feeding a single-outstanding memory read port,
// with SLVERR/DECERR responses, a per-access timeout and back-to-back issue from RESP.
module axi4_lite_slave_read_pipe #(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                       clk_i,
    input  logic                       arst_i,
    input  logic                       AR_VALID,
    input  logic [AXI_ADDR_WIDTH-1:0]  AR_ADDR,
    input  logic [2:0]                 AR_PROT,
    output logic                       AR_READY,
    input  logic                       R_READY,
    output logic [AXI_DATA_WIDTH-1:0]  R_DATA,
    output logic [1:0]                 R_RESP,
    output logic                       R_VALID,
    output logic                       mem_req_o,
    output logic [AXI_ADDR_WIDTH-1:0]  mem_addr_o,
    output logic [2:0]                 mem_prot_o,
    input  logic                       mem_ack_i,
    input  logic [AXI_DATA_WIDTH-1:0]  mem_data_i,
    input  logic                       mem_err_i,
    output logic [$clog2(DEPTH+1)-1:0] outstanding_o,
    output logic                       timeout_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH+1);
    localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES+1);

    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);
    localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]      RespOkay   = 2'b00;
    localparam logic [1:0]      RespSlvErr = 2'b10;
    localparam logic [1:0]      RespDecErr = 2'b11;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    logic [AXI_ADDR_WIDTH-1:0] r_fifo_addr [DEPTH];
    logic [2:0]                r_fifo_prot [DEPTH];
    logic [PtrW-1:0]           r_wptr, r_rptr;
    logic [CntW-1:0]           r_count, w_count_nxt;
    logic                      w_push, w_pop, w_fifo_empty;

    state_e                    r_state, w_state_nxt;
    logic                      r_req, w_req_nxt;
    logic [AXI_ADDR_WIDTH-1:0] r_maddr, w_maddr_nxt;
    logic [2:0]                r_mprot, w_mprot_nxt;
    logic [TmrW-1:0]           r_timer, w_timer_nxt;
    logic                      r_rvalid, w_rvalid_nxt;
    logic [AXI_DATA_WIDTH-1:0] r_rdata, w_rdata_nxt;
    logic [1:0]                r_rresp, w_rresp_nxt;
    logic                      r_timeout, w_timeout_nxt;
    logic [CntW-1:0]           r_outstanding, w_outstanding_nxt;

    // Ready comes from the registered count only, so a same-cycle pop never admits a push
    // into a full FIFO; forced low while reset is held.
    assign AR_READY     = !arst_i && (r_count != CntFull);
    assign w_push       = AR_VALID && AR_READY;
    assign w_fifo_empty = (r_count == '0);

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo_addr[r_wptr] <= AR_ADDR;
            r_fifo_prot[r_wptr] <= AR_PROT;
        end
    end

    // Next FIFO occupancy; simultaneous push and pop cancel out.
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CntW'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CntW'(1);
        end
    end

    // Next-state and registered-output logic for the IDLE/WAIT/RESP access sequencer.
    always_comb begin
        w_state_nxt   = r_state;
        w_pop         = 1'b0;
        w_req_nxt     = r_req;
        w_maddr_nxt   = r_maddr;
        w_mprot_nxt   = r_mprot;
        w_timer_nxt   = r_timer;
        w_rvalid_nxt  = r_rvalid;
        w_rdata_nxt   = r_rdata;
        w_rresp_nxt   = r_rresp;
        w_timeout_nxt = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_pop = !w_fifo_empty;
            end
            StWait: begin
                // Ack has priority over a timeout landing in the same cycle.
                if (mem_ack_i) begin
                    w_rdata_nxt  = mem_data_i;
                    w_rresp_nxt  = mem_err_i ? RespSlvErr : RespOkay;
                    w_rvalid_nxt = 1'b1;
                    w_req_nxt    = 1'b0;
                    w_state_nxt  = StResp;
                end else if (r_timer == TmrLast) begin
                    w_rdata_nxt   = '0;
                    w_rresp_nxt   = RespDecErr;
                    w_rvalid_nxt  = 1'b1;
                    w_req_nxt     = 1'b0;
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = StResp;
                end else begin
                    w_timer_nxt = r_timer + TmrW'(1);
                end
            end
            StResp: begin
                if (R_READY) begin
                    w_rvalid_nxt = 1'b0;
                    if (w_fifo_empty) begin
                        w_state_nxt = StIdle;
                    end else begin
                        w_pop = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
        // Issuing from either IDLE or RESP loads the head entry and starts a fresh wait.
        if (w_pop) begin
            w_state_nxt = StWait;
            w_req_nxt   = 1'b1;
            w_maddr_nxt = r_fifo_addr[r_rptr];
            w_mprot_nxt = r_fifo_prot[r_rptr];
            w_timer_nxt = '0;
        end
        w_outstanding_nxt = w_count_nxt + CntW'(w_state_nxt != StIdle);
    end

    // FIFO pointers and count.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PtrW'(1);
            end
            r_count <= w_count_nxt;
        end
    end

    // Sequencer state and all registered outputs.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state       <= StIdle;
            r_req         <= 1'b0;
            r_maddr       <= '0;
            r_mprot       <= '0;
            r_timer       <= '0;
            r_rvalid      <= 1'b0;
            r_rdata       <= '0;
            r_rresp       <= '0;
            r_timeout     <= 1'b0;
            r_outstanding <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_req         <= w_req_nxt;
            r_maddr       <= w_maddr_nxt;
            r_mprot       <= w_mprot_nxt;
            r_timer       <= w_timer_nxt;
            r_rvalid      <= w_rvalid_nxt;
            r_rdata       <= w_rdata_nxt;
            r_rresp       <= w_rresp_nxt;
            r_timeout     <= w_timeout_nxt;
            r_outstanding <= w_outstanding_nxt;
        end
    end

    assign mem_req_o     = r_req;
    assign mem_addr_o    = r_maddr;
    assign mem_prot_o    = r_mprot;
    assign R_VALID       = r_rvalid;
    assign R_DATA        = r_rdata;
    assign R_RESP        = r_rresp;
    assign timeout_o     = r_timeout;
    assign outstanding_o = r_outstanding;

endmodule

// File: tb/tb_axi4_lite_slave_read_pipe.sv
// Bench for axi4_lite_slave_read_pipe: directed scenarios plus random traffic, checked by a
// scoreboard whose expected beats derive from the address (latency, error, data encoded in it).
module tb_axi4_lite_slave_read_pipe;

    localparam int unsigned AW    = 64;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam int          TO    = 8;
    localparam int unsigned OW    = $clog2(DEPTH+1);

    logic          clk_i = 1'b0;
    logic          arst_i = 1'b1;
    logic          AR_VALID = 1'b0;
    logic [AW-1:0] AR_ADDR = '0;
    logic [2:0]    AR_PROT = '0;
    logic          AR_READY;
    logic          R_READY = 1'b0;
    logic [DW-1:0] R_DATA;
    logic [1:0]    R_RESP;
    logic          R_VALID;
    logic          mem_req_o;
    logic [AW-1:0] mem_addr_o;
    logic [2:0]    mem_prot_o;
    logic          mem_ack_i = 1'b0;
    logic [DW-1:0] mem_data_i = '0;
    logic          mem_err_i = 1'b0;
    logic [OW-1:0] outstanding_o;
    logic          timeout_o;

    axi4_lite_slave_read_pipe #(
        .AXI_ADDR_WIDTH(AW),
        .AXI_DATA_WIDTH(DW),
        .DEPTH         (DEPTH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i        (clk_i),
        .arst_i       (arst_i),
        .AR_VALID     (AR_VALID),
        .AR_ADDR      (AR_ADDR),
        .AR_PROT      (AR_PROT),
        .AR_READY     (AR_READY),
        .R_READY      (R_READY),
        .R_DATA       (R_DATA),
        .R_RESP       (R_RESP),
        .R_VALID      (R_VALID),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_prot_o   (mem_prot_o),
        .mem_ack_i    (mem_ack_i),
        .mem_data_i   (mem_data_i),
        .mem_err_i    (mem_err_i),
        .outstanding_o(outstanding_o),
        .timeout_o    (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [1:0]    resp;
    } exp_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [2:0]    prot;
    } iss_t;

    exp_t sb[$];
    iss_t iq[$];
    int   model_out = 0;
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: got no event want event within bound", name);
    endtask

    // Memory behaviour encoded in the address: addr[7:4] = ack latency in req cycles
    // (0 means 2), addr[8] = error flag, data = addr[63:32] ^ addr[31:0].
    function automatic int lat_of(input logic [AW-1:0] a);
        return (a[7:4] == 4'd0) ? 2 : int'(a[7:4]);
    endfunction

    function automatic exp_t expect_of(input logic [AW-1:0] a);
        exp_t e;
        if (lat_of(a) <= TO) begin
            e.resp = a[8] ? 2'b10 : 2'b00;
            e.data = a[63:32] ^ a[31:0];
        end else begin
            e.resp = 2'b11;
            e.data = '0;
        end
        return e;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] a;
        a = {$urandom, $urandom};
        a[7:4] = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
        return a;
    endfunction

    // Memory model: acks on the L-th cycle of a request, toggles junk ack while idle.
    int            cyc = 0;
    logic [AW-1:0] ma = '0;
    iss_t          it;
    always @(posedge clk_i) begin
        #1;
        if (arst_i) begin
            cyc = 0;
            mem_ack_i = 1'b0;
        end else if (mem_req_o) begin
            cyc++;
            if (cyc == 1) begin
                ma = mem_addr_o;
                if (iq.size() == 0) begin
                    chk("issue_unexpected", 64'(mem_req_o), 64'(0));
                end else begin
                    it = iq.pop_front();
                    chk("mem_addr", 64'(mem_addr_o), 64'(it.addr));
                    chk("mem_prot", 64'(mem_prot_o), 64'(it.prot));
                end
            end else begin
                chk("mem_addr_stable", 64'(mem_addr_o), 64'(ma));
            end
            mem_ack_i  = (cyc == lat_of(ma));
            mem_data_i = mem_ack_i ? (ma[63:32] ^ ma[31:0]) : $urandom;
            mem_err_i  = mem_ack_i ? ma[8] : 1'($urandom);
        end else begin
            if (cyc != 0) begin
                chk("req_cycles", 64'(cyc), 64'((lat_of(ma) <= TO) ? lat_of(ma) : TO));
            end
            cyc = 0;
            mem_ack_i  = ($urandom_range(0, 3) == 0);
            mem_data_i = $urandom;
            mem_err_i  = 1'($urandom);
        end
    end

    // Monitor: checks values seen at the negedge, which are the values the next edge uses.
    logic          prev_hold = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic [1:0]    prev_resp = '0;
    logic          pend1 = 1'b0;
    logic          pend2 = 1'b0;
    logic          exp_b2b = 1'b0;
    logic          new_beat, exp_to;
    exp_t          e;
    always @(negedge clk_i) begin
        if (arst_i) begin
            sb.delete();
            iq.delete();
            model_out = 0;
            prev_hold = 1'b0;
            pend1 = 1'b0;
            pend2 = 1'b0;
            exp_b2b = 1'b0;
        end else begin
            chk("outstanding", 64'(outstanding_o), 64'(model_out));
            if (pend2) chk("issue_latency", 64'(mem_req_o), 64'(1));
            if (pend1) chk("idle_gap", 64'(mem_req_o), 64'(0));
            pend2 = pend1;
            pend1 = 1'b0;
            if (exp_b2b) chk("b2b_reissue", 64'(mem_req_o), 64'(1));
            exp_b2b = 1'b0;
            if (prev_hold) begin
                chk("hold_valid", 64'(R_VALID), 64'(1));
                chk("hold_data", 64'(R_DATA), 64'(prev_data));
                chk("hold_resp", 64'(R_RESP), 64'(prev_resp));
            end
            new_beat = R_VALID && !prev_hold;
            exp_to   = new_beat && (sb.size() > 0) && (sb[0].resp == 2'b11);
            chk("timeout_pulse", 64'(timeout_o), 64'(exp_to));
            if (R_VALID && R_READY) begin
                if (sb.size() == 0) begin
                    chk("spurious_beat", 64'(R_VALID), 64'(0));
                end else begin
                    e = sb.pop_front();
                    chk("r_data", 64'(R_DATA), 64'(e.data));
                    chk("r_resp", 64'(R_RESP), 64'(e.resp));
                    exp_b2b = (sb.size() > 0);
                    model_out--;
                end
            end
            prev_hold = R_VALID && !R_READY;
            prev_data = R_DATA;
            prev_resp = R_RESP;
            if (AR_VALID && AR_READY) begin
                if (model_out == 0) pend1 = 1'b1;
                sb.push_back(expect_of(AR_ADDR));
                iq.push_back('{addr: AR_ADDR, prot: AR_PROT});
                model_out++;
            end
        end
    end

    task automatic send(input logic [AW-1:0] a, input logic [2:0] p);
        AR_VALID = 1'b1;
        AR_ADDR  = a;
        AR_PROT  = p;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            if (AR_READY) begin
                @(posedge clk_i);
                #1;
                AR_VALID = 1'b0;
                return;
            end
            @(posedge clk_i);
            #1;
        end
        AR_VALID = 1'b0;
        fail("send_bound");
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (model_out != 0 && k < budget) begin
            @(negedge clk_i);
            #1;
            k++;
        end
        if (model_out != 0) fail("drain_bound");
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_all_zero(input string tag, input logic ready_exp);
        chk({tag, "_ar_ready"}, 64'(AR_READY), 64'(ready_exp));
        chk({tag, "_r_valid"}, 64'(R_VALID), 64'(0));
        chk({tag, "_r_data"}, 64'(R_DATA), 64'(0));
        chk({tag, "_r_resp"}, 64'(R_RESP), 64'(0));
        chk({tag, "_mem_req"}, 64'(mem_req_o), 64'(0));
        chk({tag, "_mem_addr"}, 64'(mem_addr_o), 64'(0));
        chk({tag, "_mem_prot"}, 64'(mem_prot_o), 64'(0));
        chk({tag, "_outstanding"}, 64'(outstanding_o), 64'(0));
        chk({tag, "_timeout"}, 64'(timeout_o), 64'(0));
    endtask

    int acc;
    int k;
    bit accepted;

    initial begin
        // Reset values.
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_all_zero("reset", 1'b0);
        #2 arst_i = 1'b0;
        #1 chk("ar_ready_release", 64'(AR_READY), 64'(1));
        @(posedge clk_i);
        #1;

        // Single read, error read, timeout followed by a normal access.
        R_READY = 1'b1;
        send({32'hDEAD_AEEF, 32'h0000_1000}, 3'd5);
        drain(100);
        send({32'h0000_1334, 32'h0000_0100}, 3'd2);
        drain(100);
        send({32'h5555_0000, 32'h0000_00F0}, 3'd1);
        send({32'h0000_0000, 32'h0000_0030}, 3'd6);
        drain(100);

        // Fill with R stalled: one in flight plus DEPTH queued, sixth offer refused.
        R_READY  = 1'b0;
        acc      = 0;
        AR_VALID = 1'b1;
        AR_ADDR  = {32'h0, 32'h0000_0030};
        AR_PROT  = 3'd0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk_i);
            accepted = AR_READY;
            @(posedge clk_i);
            #1;
            if (accepted) begin
                acc++;
                AR_ADDR = {32'(acc) * 32'h111, 32'h0000_0030 + 32'(acc << 12)};
                AR_PROT = 3'(acc);
            end
        end
        chk("fill_accepted", 64'(acc), 64'(DEPTH + 1));
        chk("fill_ar_ready", 64'(AR_READY), 64'(0));
        chk("fill_outstanding", 64'(outstanding_o), 64'(DEPTH + 1));
        R_READY = 1'b1;
        k = 0;
        while (!AR_READY && k < 100) begin
            @(posedge clk_i);
            #1;
            k++;
        end
        if (!AR_READY) fail("fill_ready_return");
        @(posedge clk_i);
        #1;
        AR_VALID = 1'b0;
        drain(200);

        // Back-to-back: three quick accesses with R always ready.
        send({32'hA000_0001, 32'h0000_0010}, 3'd1);
        send({32'hA000_0002, 32'h0000_1010}, 3'd2);
        send({32'hA000_0003, 32'h0000_2110}, 3'd3);
        drain(100);

        // Reset while one access waits and two are queued.
        send({32'h0, 32'h0000_00F0}, 3'd1);
        send({32'h0, 32'h0000_10F0}, 3'd2);
        send({32'h0, 32'h0000_20F0}, 3'd3);
        k = 0;
        while (!mem_req_o && k < 50) begin
            @(posedge clk_i);
            #1;
            k++;
        end
        if (!mem_req_o) fail("rst_wait_req");
        @(posedge clk_i);
        #3 arst_i = 1'b1;
        #1 check_all_zero("midrst", 1'b0);
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        #2 arst_i = 1'b0;
        repeat (30) @(posedge clk_i);
        #1;
        chk("post_rst_outstanding", 64'(outstanding_o), 64'(0));
        chk("post_rst_ar_ready", 64'(AR_READY), 64'(1));
        chk("post_rst_r_valid", 64'(R_VALID), 64'(0));

        // Random traffic with random R backpressure.
        for (int c = 0; c < 2500; c++) begin
            @(negedge clk_i);
            accepted = AR_VALID && AR_READY;
            @(posedge clk_i);
            #1;
            if (accepted || !AR_VALID) begin
                AR_VALID = ($urandom_range(0, 3) != 0);
                AR_ADDR  = rand_addr();
                AR_PROT  = 3'($urandom);
            end
            R_READY = ($urandom_range(0, 2) != 0);
        end
        AR_VALID = 1'b0;
        R_READY  = 1'b1;
        drain(3000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi4_lite_slave_read_pipe.md
Name: axi4_lite_slave_read_pipe

Overview:
- Parametrised AXI4-Lite read slave that accepts up to DEPTH outstanding AR requests into an in-order address FIFO.
- Issues requests one at a time to a memory-side req/ack port and returns R beats in AR-acceptance order.
- Adds SLVERR/DECERR responses, a per-access timeout and back-to-back issue.
- Sits between the AXI interconnect and the memory/peripheral read port.

Parameters:
- AXI_ADDR_WIDTH, 64: AR_ADDR / mem_addr_o width.
- AXI_DATA_WIDTH, 32: R_DATA / mem_data_i width.
- DEPTH, 4: AR FIFO entries, power of two, >= 2.
- TIMEOUT_CYCLES, 255: maximum cycles in WAIT before a DECERR is forced; must be >= 1.

Ports:
- clk_i  in  1  clock.
- arst_i  in  1  reset, asynchronous, active-high.
- AR_VALID  in  1  read address valid.
- AR_ADDR  in  AXI_ADDR_WIDTH  read address.
- AR_PROT  in  3  protection bits, stored with the address.
- AR_READY  out  1  FIFO has space.
- R_READY  in  1  master accepts R beat.
- R_DATA  out  AXI_DATA_WIDTH  read data.
- R_RESP  out  2  00 OKAY, 10 SLVERR, 11 DECERR.
- R_VALID  out  1  R beat valid.
- mem_req_o  out  1  memory access request, held until ack or timeout.
- mem_addr_o  out  AXI_ADDR_WIDTH  address of the current access.
- mem_prot_o  out  3  AR_PROT of the current access.
- mem_ack_i  in  1  memory access complete, sampled only while mem_req_o=1.
- mem_data_i  in  AXI_DATA_WIDTH  read data, valid with mem_ack_i.
- mem_err_i  in  1  access error, valid with mem_ack_i.
- outstanding_o  out  $clog2(DEPTH+1)  FIFO count plus 1 if an access is in WAIT or RESP.
- timeout_o  out  1  one-cycle pulse when a timeout fires.

Behaviour:
- Reset values:
  - All outputs 0; AR_READY=0 while arst_i is high, 1 in the first cycle after release.
  - FIFO empty, FSM in IDLE, timer 0.
- Reset mid-operation drops all queued and in-flight requests with no R beat; mem_req_o falls immediately (asynchronous).
- AR_READY = (fifo_count != DEPTH), derived from registered count.
  - AR handshake (AR_VALID & AR_READY) pushes {AR_ADDR, AR_PROT}.
  - A same-cycle pop does not raise AR_READY when the FIFO is full.
  - Push and pop in the same cycle leave the count unchanged.
- FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count range is 0..DEPTH.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If the FIFO is non-empty: pop the head, register mem_addr_o/mem_prot_o, set mem_req_o=1, clear the timer, go to WAIT.
  - An AR accepted at edge N is therefore popped at edge N+1, with mem_req_o high from N+1.
- WAIT:
  - mem_req_o stays 1 and the timer increments each cycle.
  - On mem_ack_i: R_DATA<=mem_data_i; R_RESP<=mem_err_i?10:00; R_VALID<=1; mem_req_o<=0; go to RESP.
  - Else, if timer == TIMEOUT_CYCLES-1: R_DATA<=0; R_RESP<=11; R_VALID<=1; mem_req_o<=0; timeout_o pulses; go to RESP.
  - If ack and timeout coincide, ack wins.
- RESP:
  - R_VALID, R_DATA and R_RESP are held stable until R_READY.
  - On R_VALID & R_READY: R_VALID<=0.
  - If the FIFO is non-empty, pop and issue the next access in the same edge (straight to WAIT, mem_req_o=1). Otherwise go to IDLE.
- Ordering: R beats return strictly in AR acceptance order. R_RESP for a beat depends only on its own access.
- mem_addr_o/mem_prot_o are stable while mem_req_o=1.
- mem_ack_i while mem_req_o=0 is ignored.
- outstanding_o is registered, updated each edge, and never exceeds DEPTH+1.

Test Plan:
- Single read: AR 0x1000 with R_READY=1; mem acks 2 cycles after req with data 0xDEADBEEF and err=0. Required: mem_req_o at N+1, mem_addr_o=0x1000, R_VALID one cycle after ack, R_DATA=0xDEADBEEF, R_RESP=00.
- Fill/backpressure: DEPTH=4, R_READY=0, memory stalled, 6 ARs offered. Required: 5 accepted (1 issued + 4 queued), AR_READY=0 afterwards, outstanding_o=5. Then release: 5 R beats in address order, AR_READY reasserts after the first pop.
- Error: mem_ack_i with mem_err_i=1 and data 0x1234. Required: R_RESP=10, R_DATA=0x1234.
- Timeout: TIMEOUT_CYCLES=8, no ack. Required: mem_req_o high for exactly 8 cycles, timeout_o single pulse, R_RESP=11, R_DATA=0. The next queued access then issues normally.
- Back-to-back: 3 queued ARs with immediate acks and R_READY=1. Required: mem_req_o re-asserts on the same edge as each R handshake, with no IDLE cycle between beats.
- Reset mid-WAIT with 2 queued: assert arst_i. Required: all outputs 0 immediately. After release, no R beat is produced, outstanding_o=0, AR_READY=1.
